// File: rtl/pixel_packer_pkg.sv
// Shared types and constants for the pixel line packer slice.
package pixel_packer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        FLUSH,
        DONE,
        DROP
    } state_t;

    localparam logic        BANK0  = 1'b0;
    localparam logic        BANK1  = 1'b1;
    localparam int unsigned PIX_W  = 16;
    localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/pixel_pair_packer.sv
// Packs consecutive 16-bit pixels into 32-bit words {odd, even}; pads a lone even pixel on flush.
module pixel_pair_packer
    import pixel_packer_pkg::*;
#(
    parameter int unsigned IDX_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              accept,
    input  logic              flush,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              wr,
    output logic [IDX_W-1:0]  word_idx,
    output logic [WORD_W-1:0] word_data
);

    logic [PIX_W-1:0] even_q;
    logic             have_even;
    logic [IDX_W-1:0] next_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            even_q    <= '0;
            have_even <= 1'b0;
            next_idx  <= '0;
            wr        <= 1'b0;
            word_idx  <= '0;
            word_data <= '0;
        end else begin
            wr <= 1'b0;
            if (clear) begin
                have_even <= 1'b0;
                next_idx  <= '0;
            end else if (accept) begin
                if (!have_even) begin
                    even_q    <= pix_data;
                    have_even <= 1'b1;
                end else begin
                    wr        <= 1'b1;
                    word_data <= {pix_data, even_q};
                    word_idx  <= next_idx;
                    next_idx  <= next_idx + 1'b1;
                    have_even <= 1'b0;
                end
            end else if (flush && have_even) begin
                wr        <= 1'b1;
                word_data <= {{PIX_W{1'b0}}, even_q};
                word_idx  <= next_idx;
                next_idx  <= next_idx + 1'b1;
                have_even <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pixel_line_packer.sv
// Packs one sensor line into a ping-pong BRAM bank and signals completion to the PS.
// Optional PIXEL_LINE_PACKER_SUM_EN adds a per-line pixel sum output.
module pixel_line_packer
    import pixel_packer_pkg::*;
#(
    parameter int unsigned PIX_PER_LINE = 256,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable_in,
    input  logic              line_start_in,
    input  logic [15:0]       pix_data_in,
    input  logic              pix_valid_in,
    input  logic              line_end_in,
    input  logic [1:0]        buf_release_in,
    output logic              ram_wr_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    output logic              line_done_o,
    output logic              done_bank_o,
    output logic [15:0]       line_len_o,
    output logic              overflow_o
`ifdef PIXEL_LINE_PACKER_SUM_EN
    ,
    output logic [31:0]       line_sum_o
`endif
);

    localparam int unsigned       CNT_W      = $clog2(PIX_PER_LINE + 1);
    localparam int unsigned       IDX_W      = $clog2(PIX_PER_LINE);
    localparam logic [CNT_W-1:0]  PIX_MAX    = CNT_W'(PIX_PER_LINE);
    localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(PIX_PER_LINE * 2);

    state_t           state;
    logic             wr_bank;
    logic [1:0]       busy;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] wr_idx;
    logic             accept;
    logic             start_ok;

`ifdef PIXEL_LINE_PACKER_SUM_EN
    logic [31:0] sum_acc;
`endif

    assign start_ok = (state == IDLE) && line_start_in && enable_in && !busy[wr_bank];
    assign accept   = (state == CAPTURE) && pix_valid_in && (count != PIX_MAX);

    pixel_pair_packer #(
        .IDX_W (IDX_W)
    ) u_pair (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_ok),
        .accept    (accept),
        .flush     (state == FLUSH),
        .pix_data  (pix_data_in),
        .wr        (ram_wr_o),
        .word_idx  (wr_idx),
        .word_data (ram_data_o)
    );

    // wr_bank only toggles in DONE, after the final write has left the packer
    assign ram_addr_o = (wr_bank ? BANK1_BASE : '0) + ADDR_W'({wr_idx, 2'b00});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_bank     <= BANK0;
            busy        <= '0;
            count       <= '0;
            line_done_o <= 1'b0;
            done_bank_o <= 1'b0;
            line_len_o  <= '0;
            overflow_o  <= 1'b0;
`ifdef PIXEL_LINE_PACKER_SUM_EN
            sum_acc     <= '0;
            line_sum_o  <= '0;
`endif
        end else begin
            line_done_o <= 1'b0;
            busy        <= busy & ~buf_release_in;
            case (state)
                IDLE: begin
                    if (line_start_in && enable_in) begin
                        if (busy[wr_bank]) begin
                            state      <= DROP;
                            overflow_o <= 1'b1;
                        end else begin
                            state   <= CAPTURE;
                            count   <= '0;
`ifdef PIXEL_LINE_PACKER_SUM_EN
                            sum_acc <= '0;
`endif
                        end
                    end
                end
                CAPTURE: begin
                    if (accept) begin
                        count   <= count + 1'b1;
`ifdef PIXEL_LINE_PACKER_SUM_EN
                        sum_acc <= sum_acc + 32'(pix_data_in);
`endif
                    end
                    if (line_end_in) state <= FLUSH;
                end
                FLUSH: state <= DONE;
                DONE: begin
                    line_done_o   <= 1'b1;
                    done_bank_o   <= wr_bank;
                    line_len_o    <= 16'(count);
                    // later assignment overrides a same-cycle release of this bank
                    busy[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
`ifdef PIXEL_LINE_PACKER_SUM_EN
                    line_sum_o    <= sum_acc;
`endif
                    state         <= IDLE;
                end
                DROP: if (line_end_in) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
